return_address_stack: RTL
=========================

# return_address_stack

Speculative return address stack (RAS) in the fetch stage, directly downstream of the branch target buffer. When the BTB marks the fetch PC as a call, the RAS pushes the return address. When the BTB marks it as a return, the RAS supplies the predicted target in the same cycle. On a branch misprediction, the back end restores the top-of-stack state from a checkpoint that fetch attached to the branch.

## Interface
- DEPTH, 8, number of stack entries; power of two, minimum 2
- PTR_W, 3, log2(DEPTH)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- fetch_valid  input  1  fetch_pc/btb_* are valid this cycle (low = stall, no action)
- fetch_pc  input  32  PC of the fetched instruction
- btb_hit  input  2  BTB way-hit vector; 2'b00 = miss
- btb_type  input  2  2'b00 direct, 2'b01 call, 2'b10 return, 2'b11 indirect
- predict_valid  output  1  predict_target is usable
- predict_target  output  32  predicted return address (top of stack)
- ckpt_tos  output  PTR_W  current top-of-stack index, carried with the branch
- ckpt_count  output  PTR_W+1  current occupancy, carried with the branch
- ras_empty  output  1  count == 0
- ras_full  output  1  count == DEPTH
- recover_en  input  1  misprediction recovery this cycle
- recover_tos  input  PTR_W  checkpointed tos of the mispredicted branch
- recover_count  input  PTR_W+1  checkpointed count of the mispredicted branch
- recover_type  input  2  actual type of the mispredicted branch (same encoding as btb_type)
- recover_pc  input  32  PC of the mispredicted branch

## Operation
- State: stack[0..DEPTH-1] (32 b each), tos (PTR_W), count (PTR_W+1). tos indexes the newest valid entry; the stack is circular.
- Fetch is a call when fetch_valid & (btb_hit != 0) & (btb_type == 2'b01). Fetch is a return under the same condition with btb_type == 2'b10.
- Push (call):
  - stack[tos+1] <= fetch_pc + 8 (return address past the delay slot); tos <= tos+1.
  - count <= min(count+1, DEPTH).
  - Overflow at DEPTH overwrites the oldest entry silently; tos wraps mod DEPTH.
- Pop (return):
  - If count != 0: tos <= tos-1 (wraps mod DEPTH), count <= count-1.
  - If count == 0: no state change.
- predict_valid = fetch is a return & count != 0. predict_target = stack[tos], driven combinationally.
- predict_target = 32'd0 whenever predict_valid is 0.
- ckpt_tos/ckpt_count show the registered state before this cycle's push or pop.
- Recovery (recover_en) has priority over fetch; the fetch action in that cycle is discarded. Base state is tos <= recover_tos, count <= recover_count, then the correction:
  - recover_type 01: stack[recover_tos+1] <= recover_pc + 8; tos <= recover_tos+1; count <= min(recover_count+1, DEPTH).
  - recover_type 10: if recover_count != 0, then tos <= recover_tos-1 and count <= recover_count-1; otherwise base state only.
  - 00 or 11: base state only.
- Wrong-path pushes that overwrote entries are not repaired. Only the pointer and count are restored; this is accepted accuracy loss.
- Address arithmetic is 32-bit modulo 2^32. Pointer arithmetic is modulo DEPTH.

## Timing
- Reset (synchronous, one edge):
  - tos = 0, count = 0, all stack entries = 0.
  - Outputs after reset: predict_valid = 0, predict_target = 0, ras_empty = 1, ras_full = 0, ckpt_tos = 0, ckpt_count = 0.
- Reset asserted together with recover_en or a fetch push/pop: reset wins.
- Prediction latency is 0 cycles: combinational from registered state plus the btb_* inputs.
- A push or pop is visible on the next cycle. A call at cycle N followed by a return at N+1 predicts the address pushed at N.
- ckpt_* must be sampled in the same cycle as the fetched branch.
- Recovery takes effect at the edge where recover_en is high. The first fetch after that edge sees the restored state.
- A stall (fetch_valid = 0) holds all state.

## Test plan
- Reset, then a return fetch → predict_valid = 0, tos/count unchanged, ras_empty = 1.
- Calls at PC 0x100 and 0x200, then two returns → predict_target 0x208 then 0x108; ras_empty = 1 after the second return.
- DEPTH+1 (9) calls at 0x1000, 0x1010, ... 0x1080, then 9 returns:
  - ras_full = 1 after the 8th call; count stays 8.
  - Returns predict 0x1088 down to 0x1018, then predict_valid = 0.
- Checkpoint (tos = 1, count = 2) taken at a branch; 3 wrong-path calls; recover_en with type 00 → tos = 1, count = 2; next return predicts the pre-branch top.
- recover_en with recover_type 01, recover_pc 0x400, issued in the same cycle as a fetch call at 0x500 → stack holds 0x408 at recover_tos+1; 0x508 is never pushed.
- recover_type 10 with recover_count 0 → count stays 0, no underflow wrap.

Source files
------------

// File: rtl/return_address_stack.sv
// Speculative return address stack for the fetch stage.
// Calls push pc+8, returns predict the top entry combinationally. A
// mispredicting branch restores the tos/count checkpoint taken at fetch, then
// replays its own call/return effect. Entries overwritten on the wrong path
// are not repaired.
module return_address_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_valid,
  input  logic [31:0]        fetch_pc,
  input  logic [1:0]         btb_hit,
  input  logic [1:0]         btb_type,
  output logic               predict_valid,
  output logic [31:0]        predict_target,
  output logic [PTR_W-1:0]   ckpt_tos,
  output logic [PTR_W:0]     ckpt_count,
  output logic               ras_empty,
  output logic               ras_full,
  input  logic               recover_en,
  input  logic [PTR_W-1:0]   recover_tos,
  input  logic [PTR_W:0]     recover_count,
  input  logic [1:0]         recover_type,
  input  logic [31:0]        recover_pc
);

  localparam logic [1:0]     T_CALL  = 2'b01;
  localparam logic [1:0]     T_RET   = 2'b10;
  localparam logic [PTR_W:0] FULL_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DEPTH-1:0][31:0] stack_q;
  logic [PTR_W-1:0]       tos_q, tos_d;
  logic [PTR_W:0]         count_q, count_d;

  logic                   wr_en;
  logic [PTR_W-1:0]       wr_idx;
  logic [31:0]            wr_data;

  logic                   btb_any;
  logic                   is_call, is_ret;

  // BTB classification of the current fetch
  always_comb begin
    btb_any = |btb_hit;
    is_call = fetch_valid && btb_any && (btb_type == T_CALL);
    is_ret  = fetch_valid && btb_any && (btb_type == T_RET);
  end

  // Zero-latency prediction and checkpoint/status outputs from registered state
  always_comb begin
    predict_valid  = is_ret && (count_q != '0);
    predict_target = predict_valid ? stack_q[tos_q] : 32'd0;
    ckpt_tos       = tos_q;
    ckpt_count     = count_q;
    ras_empty      = (count_q == '0);
    ras_full       = (count_q == FULL_C);
  end

  // Next-state: recovery overrides fetch; pushes saturate count, pops stop at empty
  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = tos_q + PTR_ONE;
    wr_data = fetch_pc + 32'd8;
    if (recover_en) begin
      tos_d   = recover_tos;
      count_d = recover_count;
      if (recover_type == T_CALL) begin
        wr_en   = 1'b1;
        wr_idx  = recover_tos + PTR_ONE;
        wr_data = recover_pc + 32'd8;
        tos_d   = recover_tos + PTR_ONE;
        // >= guards against an out-of-range checkpoint ever exceeding DEPTH
        count_d = (recover_count >= FULL_C) ? FULL_C : recover_count + CNT_ONE;
      end else if (recover_type == T_RET) begin
        if (recover_count != '0) begin
          tos_d   = recover_tos - PTR_ONE;
          count_d = recover_count - CNT_ONE;
        end
      end
    end else if (is_call) begin
      // On overflow the slot at tos+1 is the oldest entry; it is overwritten
      wr_en   = 1'b1;
      tos_d   = tos_q + PTR_ONE;
      count_d = (count_q == FULL_C) ? FULL_C : count_q + CNT_ONE;
    end else if (is_ret && (count_q != '0)) begin
      tos_d   = tos_q - PTR_ONE;
      count_d = count_q - CNT_ONE;
    end
  end

  // Pointer/count registers; synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q   <= '0;
      count_q <= '0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
    end
  end

  // Stack storage: single write port, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stack_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == PTR_W'(i)) stack_q[i] <= wr_data;
      end
    end
  end

endmodule
